// File: rtl/tx_module.sv
// tx_module: UART transmitter with 16x oversampling.
// Frame layout: start bit (0), 5..8 data bits LSB first, optional even
// parity bit, then 1..4 stop bits (1). Each bit lasts 16 baud_en_i ticks.
// Optional feature: define UART_TX_HOLD_REG_EN to add a one-entry hold
// register. With it, a second character can be queued while a frame is
// being sent, and frames then run back to back. The default build has no
// hold logic.
module tx_module #(
  parameter int MAX_UART_DATA_W  = 8,
  parameter int TOTAL_CONF_WIDTH = 5
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        baud_en_i,
  input  logic                        tx_en_i,
  input  logic [TOTAL_CONF_WIDTH-1:0] tx_conf_i,
  input  logic                        tx_start_i,
  input  logic [MAX_UART_DATA_W-1:0]  tx_data_i,
  output logic                        tx_ready_o,
  output logic                        tx_busy_o,
  output logic                        tx_done_o,
  output logic                        uart_tx_o
);

  // Wide enough to hold the index of the last data bit (up to MAX-1).
  localparam int BIT_CNT_W = $clog2(MAX_UART_DATA_W + 1);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_IDLE   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

  state_t                      state;
  logic [3:0]                  sample_cnt;
  logic [BIT_CNT_W-1:0]        bit_cnt;
  logic [1:0]                  stop_cnt;
  logic [MAX_UART_DATA_W-1:0]  shift_reg;
  logic [TOTAL_CONF_WIDTH-1:0] conf_reg;
  logic                        pending;
  logic                        parity_acc;
  logic                        uart_tx;
  logic                        busy;
  logic                        done;

  logic                        ready;
  logic                        accept;
  logic                        load_direct;
  logic                        last_sample;
  logic [BIT_CNT_W-1:0]        last_bit;
  logic [1:0]                  last_stop;
  logic                        parity_en;

`ifdef UART_TX_HOLD_REG_EN
  logic [MAX_UART_DATA_W-1:0]  hold_data;
  logic [TOTAL_CONF_WIDTH-1:0] hold_conf;
  logic                        hold_vld;
  logic                        load_hold;
  logic                        hold_take;
`endif

  // Decoded fields of the configuration latched for the current frame.
  assign last_bit    = BIT_CNT_W'(conf_reg[4:3]) + BIT_CNT_W'(4);
  assign last_stop   = conf_reg[2:1];
  assign parity_en   = conf_reg[0];
  assign last_sample = (sample_cnt == 4'd15);

`ifdef UART_TX_HOLD_REG_EN
  // The hold entry accepts whenever it is empty, even mid-frame. A request
  // seen in Idle with nothing pending goes straight to the shift register.
  assign ready       = tx_en_i && !hold_vld;
  assign accept      = tx_start_i && ready;
  assign load_direct = accept && (state == ST_IDLE) && !pending;
  assign load_hold   = accept && !load_direct;
  // The hold entry is drained into the shift register either in Idle (when
  // nothing is pending) or at the end of the Done tick for back-to-back frames.
  assign hold_take   = hold_vld &&
                       (((state == ST_IDLE) && !pending) ||
                        (baud_en_i && (state == ST_DONE)));
`else
  // Ready depends on tx_en_i directly so that a request is refused the same
  // cycle the enable drops.
  assign ready       = tx_en_i && (state == ST_IDLE) && !pending;
  assign accept      = tx_start_i && ready;
  assign load_direct = accept;
`endif

`ifdef UART_TX_HOLD_REG_EN
  // One-entry hold register: filled on acceptance, emptied when consumed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_vld  <= 1'b0;
      hold_data <= '0;
      hold_conf <= '0;
    end else if (load_hold) begin
      hold_vld  <= 1'b1;
      hold_data <= tx_data_i;
      hold_conf <= tx_conf_i;
    end else if (hold_take) begin
      hold_vld  <= 1'b0;
    end
  end
`endif

  // Transmit FSM: request latching, bit sequencing and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= ST_RESET;
      sample_cnt <= 4'd0;
      bit_cnt    <= '0;
      stop_cnt   <= 2'd0;
      shift_reg  <= '0;
      conf_reg   <= '0;
      pending    <= 1'b0;
      parity_acc <= 1'b0;
      uart_tx    <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;

      // Request acceptance is not tied to the baud tick.
      if (load_direct) begin
        shift_reg <= tx_data_i;
        conf_reg  <= tx_conf_i;
        pending   <= 1'b1;
      end
`ifdef UART_TX_HOLD_REG_EN
      else if (hold_take && (state == ST_IDLE)) begin
        shift_reg <= hold_data;
        conf_reg  <= hold_conf;
        pending   <= 1'b1;
      end
`endif

      if (baud_en_i) begin
        case (state)
          ST_RESET: begin
            uart_tx <= 1'b1;
            if (tx_en_i) state <= ST_IDLE;
          end

          ST_IDLE: begin
            uart_tx <= 1'b1;
            if (pending) begin
              state      <= ST_START;
              pending    <= 1'b0;
              sample_cnt <= 4'd0;
              parity_acc <= 1'b0;
              uart_tx    <= 1'b0;
            end else if (!tx_en_i) begin
              state <= ST_RESET;
            end
          end

          ST_START: begin
            sample_cnt <= sample_cnt + 4'd1;
            if (last_sample) begin
              state      <= ST_DATA;
              bit_cnt    <= '0;
              uart_tx    <= shift_reg[0];
              parity_acc <= parity_acc ^ shift_reg[0];
              shift_reg  <= shift_reg >> 1;
            end
          end

          // Parity accumulates only the bits actually sent, so unused high
          // bits of the character never influence it.
          ST_DATA: begin
            sample_cnt <= sample_cnt + 4'd1;
            if (last_sample) begin
              if (bit_cnt == last_bit) begin
                if (parity_en) begin
                  state   <= ST_PARITY;
                  uart_tx <= parity_acc;
                end else begin
                  state    <= ST_STOP;
                  stop_cnt <= 2'd0;
                  uart_tx  <= 1'b1;
                end
              end else begin
                bit_cnt    <= bit_cnt + BIT_CNT_W'(1);
                uart_tx    <= shift_reg[0];
                parity_acc <= parity_acc ^ shift_reg[0];
                shift_reg  <= shift_reg >> 1;
              end
            end
          end

          ST_PARITY: begin
            sample_cnt <= sample_cnt + 4'd1;
            if (last_sample) begin
              state    <= ST_STOP;
              stop_cnt <= 2'd0;
              uart_tx  <= 1'b1;
            end
          end

          ST_STOP: begin
            sample_cnt <= sample_cnt + 4'd1;
            uart_tx    <= 1'b1;
            if (last_sample) begin
              if (stop_cnt == last_stop) begin
                state <= ST_DONE;
                done  <= 1'b1;
`ifdef UART_TX_HOLD_REG_EN
                busy  <= hold_vld;
`else
                busy  <= 1'b0;
`endif
              end else begin
                stop_cnt <= stop_cnt + 2'd1;
              end
            end
          end

          ST_DONE: begin
            uart_tx <= 1'b1;
`ifdef UART_TX_HOLD_REG_EN
            if (hold_vld) begin
              state      <= ST_START;
              shift_reg  <= hold_data;
              conf_reg   <= hold_conf;
              sample_cnt <= 4'd0;
              parity_acc <= 1'b0;
              uart_tx    <= 1'b0;
            end else if (tx_en_i) begin
              state <= ST_IDLE;
            end else begin
              state <= ST_RESET;
            end
`else
            if (tx_en_i) state <= ST_IDLE;
            else         state <= ST_RESET;
`endif
          end

          default: begin
            state   <= ST_RESET;
            uart_tx <= 1'b1;
          end
        endcase
      end

      // Acceptance wins over the busy release on entry to Done.
      if (accept) busy <= 1'b1;
    end
  end

  assign tx_ready_o = ready;
  assign tx_busy_o  = busy;
  assign tx_done_o  = done;
  assign uart_tx_o  = uart_tx;

endmodule

// File: tb/tb_tx_module.sv
// tb_tx_module: table-driven bench for the UART transmitter, plus
// hand-written sequences for reset, enable drop and queued frames.
module tb_tx_module;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       baud_en_i;
  logic       tx_en_i;
  logic [4:0] tx_conf_i;
  logic       tx_start_i;
  logic [7:0] tx_data_i;
  logic       tx_ready_o;
  logic       tx_busy_o;
  logic       tx_done_o;
  logic       uart_tx_o;

  int   errors = 0;
  int   checks = 0;
  logic uart_s;
  logic done_s;

  // bits[i] is the expected line level during bit i of the frame (0 = start).
  typedef struct {
    logic [4:0]  conf;
    logic [7:0]  data;
    int          nbits;
    logic [15:0] bits;
    int          done_tick;
    int          inject_at;
    int          drop_at;
  } vec_t;

  vec_t vecs[6];

  tx_module dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .baud_en_i  (baud_en_i),
    .tx_en_i    (tx_en_i),
    .tx_conf_i  (tx_conf_i),
    .tx_start_i (tx_start_i),
    .tx_data_i  (tx_data_i),
    .tx_ready_o (tx_ready_o),
    .tx_busy_o  (tx_busy_o),
    .tx_done_o  (tx_done_o),
    .uart_tx_o  (uart_tx_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One baud tick: baud_en_i high for exactly one rising edge, then three
  // idle clocks. Called and returning at a falling edge.
  task automatic do_tick();
    baud_en_i = 1'b1;
    @(negedge clk_i);
    baud_en_i = 1'b0;
    uart_s = uart_tx_o;
    done_s = tx_done_o;
    repeat (3) @(negedge clk_i);
  endtask

  task automatic run_frame(input vec_t v);
    int done_at;
    int ndone;
    chk("ready_idle", tx_ready_o, 1'b1);
    tx_data_i  = v.data;
    tx_conf_i  = v.conf;
    tx_start_i = 1'b1;
    @(negedge clk_i);
    tx_start_i = 1'b0;
    chk("busy_accept", tx_busy_o, 1'b1);
    done_at = -1;
    ndone   = 0;
    for (int k = 0; k <= v.done_tick + 1; k++) begin
      if (k == v.drop_at) tx_en_i = 1'b0;
`ifndef UART_TX_HOLD_REG_EN
      if (k == v.inject_at) begin
        tx_data_i  = 8'h00;
        tx_conf_i  = 5'b00000;
        tx_start_i = 1'b1;
        chk("ready_busy", tx_ready_o, 1'b0);
      end
`endif
      do_tick();
      tx_start_i = 1'b0;
      if (done_s) begin
        ndone++;
        if (done_at < 0) done_at = k;
      end
      if ((k % 16) == 8 && (k / 16) < v.nbits)
        chk($sformatf("bit%0d", k / 16), uart_s, v.bits[k / 16]);
      if (k == v.done_tick) chk("line_done", uart_s, 1'b1);
    end
    chk("done_tick", done_at, v.done_tick);
    chk("done_count", ndone, 1);
    chk("busy_end", tx_busy_o, 1'b0);
    if (v.drop_at >= 0) begin
      tx_en_i = 1'b1;
      chk("ready_in_reset", tx_ready_o, 1'b0);
      do_tick();
      chk("ready_reenabled", tx_ready_o, 1'b1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // conf, data, nbits, bits, done_tick, inject_at, drop_at
    vecs[0] = '{5'b11000, 8'h55, 10, 16'h02AA, 160, -1, -1}; // 8N1
    vecs[1] = '{5'b10011, 8'hC1, 11, 16'h0682, 176, 20, -1}; // 7E2, bit 7 dropped
    vecs[2] = '{5'b00001, 8'h1F,  8, 16'h00FE, 128, -1, 30}; // 5E1, enable drops
    vecs[3] = '{5'b01010, 8'hB2,  9, 16'h01E4, 144, -1, -1}; // 6N2
    vecs[4] = '{5'b11111, 8'h80, 14, 16'h3F00, 224, -1, -1}; // 8E4
    vecs[5] = '{5'b00000, 8'hE0,  7, 16'h0040, 112, -1, -1}; // 5N1, high bits set

    rst_ni     = 1'b1;
    baud_en_i  = 1'b0;
    tx_en_i    = 1'b0;
    tx_start_i = 1'b0;
    tx_conf_i  = 5'b0;
    tx_data_i  = 8'h0;
    #2 rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("rst_line", uart_tx_o, 1'b1);
    chk("rst_ready", tx_ready_o, 1'b0);
    chk("rst_busy", tx_busy_o, 1'b0);
    chk("rst_done", tx_done_o, 1'b0);
    rst_ni  = 1'b1;
    tx_en_i = 1'b1;
    @(negedge clk_i);
    chk("ready_before_tick", tx_ready_o, 1'b0);
    do_tick();
    chk("ready_after_tick", tx_ready_o, 1'b1);

    for (int i = 0; i < 6; i++) run_frame(vecs[i]);

    // Reset in the middle of a frame forces the line high without a clock edge.
    tx_data_i  = 8'h00;
    tx_conf_i  = 5'b11000;
    tx_start_i = 1'b1;
    @(negedge clk_i);
    tx_start_i = 1'b0;
    for (int k = 0; k <= 40; k++) do_tick();
    chk("line_tick40", uart_tx_o, 1'b0);
    #1 rst_ni = 1'b0;
    #1;
    chk("rst_async_line", uart_tx_o, 1'b1);
    chk("rst_async_busy", tx_busy_o, 1'b0);
    chk("rst_async_ready", tx_ready_o, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    do_tick();
    chk("ready_after_rst", tx_ready_o, 1'b1);

`ifdef UART_TX_HOLD_REG_EN
    // Two queued characters go out back to back with a single Done tick.
    begin
      logic [9:0] f1;
      logic [9:0] f2;
      int         nd;
      int         d1;
      int         d2;
      f1 = 10'h34A; // 0, A5 LSB first, stop
      f2 = 10'h278; // 0, 3C LSB first, stop
      nd = 0;
      d1 = -1;
      d2 = -1;
      tx_data_i  = 8'hA5;
      tx_conf_i  = 5'b11000;
      tx_start_i = 1'b1;
      @(negedge clk_i);
      tx_start_i = 1'b0;
      for (int k = 0; k <= 322; k++) begin
        if (k == 5) begin
          chk("hold_ready_busy", tx_ready_o, 1'b1);
          tx_data_i  = 8'h3C;
          tx_start_i = 1'b1;
          @(negedge clk_i);
          tx_start_i = 1'b0;
        end
        do_tick();
        if (done_s) begin
          nd++;
          if (d1 < 0) d1 = k;
          else d2 = k;
        end
        if (k < 161) begin
          if ((k % 16) == 8 && (k / 16) < 10)
            chk($sformatf("f1_bit%0d", k / 16), uart_s, f1[k / 16]);
        end else begin
          if (((k - 161) % 16) == 8 && ((k - 161) / 16) < 10)
            chk($sformatf("f2_bit%0d", (k - 161) / 16), uart_s, f2[(k - 161) / 16]);
        end
        if (k == 160) chk("busy_between", tx_busy_o, 1'b1);
      end
      chk("hold_done_count", nd, 2);
      chk("hold_done1", d1, 160);
      chk("hold_done2", d2, 321);
      chk("hold_busy_end", tx_busy_o, 1'b0);
      chk("hold_ready_end", tx_ready_o, 1'b1);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
